// File: rtl/time_keeper.sv
// Time-of-day core: divides clk to a 1 s tick and keeps hh:mm:ss with load, freeze, 12/24 h view and rollover strobes.
// Optional alarm comparator is compiled in when TIME_KEEPER_ALARM_EN is defined.
module time_keeper #(
  parameter int CLK_DIV   = 100000000,
  parameter int DIV_W     = 27,
  parameter int RING_SECS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_valid,
  input  logic [5:0] set_hour,
  input  logic [5:0] set_minute,
  input  logic [5:0] set_second,
  input  logic       mode12,
  output logic       set_ack,
  output logic       set_err,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [5:0] disp_hour,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  input  logic       alarm_en,
  input  logic [5:0] alarm_hour,
  input  logic [5:0] alarm_minute,
  input  logic       alarm_clr,
  output logic       alarm_ring
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick_now;
  logic             tick_take;
  logic             load_ok;
  logic             load_bad;
  logic             sec_wrap;
  logic             min_wrap;
  logic             hr_wrap;
  logic [5:0]       nxt_hour;
  logic [5:0]       nxt_minute;
  logic [5:0]       nxt_second;

  always_comb begin
    load_ok  = set_valid && (set_hour < 6'd24) && (set_minute < 6'd60) && (set_second < 6'd60);
    load_bad = set_valid && !load_ok;
    tick_now = run && (div_cnt == DIV_LAST);
    // an accepted load owns the edge; its second restarts from zero
    tick_take = tick_now && !load_ok;
  end

  always_comb begin
    sec_wrap   = (second == 6'd59);
    min_wrap   = (minute == 6'd59);
    hr_wrap    = (hour == 6'd23);
    nxt_second = sec_wrap ? 6'd0 : second + 6'd1;
    nxt_minute = minute;
    nxt_hour   = hour;
    if (sec_wrap) begin
      nxt_minute = min_wrap ? 6'd0 : minute + 6'd1;
      if (min_wrap) nxt_hour = hr_wrap ? 6'd0 : hour + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      hour      <= '0;
      minute    <= '0;
      second    <= '0;
      set_ack   <= 1'b0;
      set_err   <= 1'b0;
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      day_tick  <= 1'b0;
    end else begin
      set_ack   <= load_ok;
      set_err   <= load_bad;
      sec_tick  <= tick_take;
      min_tick  <= tick_take && sec_wrap;
      hour_tick <= tick_take && sec_wrap && min_wrap;
      day_tick  <= tick_take && sec_wrap && min_wrap && hr_wrap;
      if (load_ok) begin
        hour    <= set_hour;
        minute  <= set_minute;
        second  <= set_second;
        div_cnt <= '0;
      end else if (tick_now) begin
        hour    <= nxt_hour;
        minute  <= nxt_minute;
        second  <= nxt_second;
        div_cnt <= '0;
      end else if (run) begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pm        = (hour >= 6'd12);
    disp_hour = hour;
    if (mode12) begin
      if (hour == 6'd0)       disp_hour = 6'd12;
      else if (hour > 6'd12)  disp_hour = hour - 6'd12;
    end
  end

`ifdef TIME_KEEPER_ALARM_EN
  // state    | meaning
  // ALM_IDLE | not ringing, waiting for a time match
  // ALM_RING | ringing; ring_cnt counts seconds since the match
  typedef enum logic {ALM_IDLE, ALM_RING} alm_state_t;

  localparam logic [5:0] RING_LAST = 6'(RING_SECS - 1);

  alm_state_t alm_state;
  alm_state_t alm_next;
  logic [5:0] ring_cnt;
  logic [5:0] ring_cnt_next;
  logic       alm_match;
  logic       alm_clear;

  always_comb begin
    alm_match = tick_take && alarm_en && (nxt_hour == alarm_hour) &&
                (nxt_minute == alarm_minute) && (nxt_second == 6'd0);
    alm_clear = alarm_clr || !alarm_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alm_state <= ALM_IDLE;
      ring_cnt  <= '0;
    end else begin
      alm_state <= alm_next;
      ring_cnt  <= ring_cnt_next;
    end
  end

  always_comb begin
    alm_next      = alm_state;
    ring_cnt_next = ring_cnt;
    case (alm_state)
      ALM_IDLE: begin
        if (alm_match && !alm_clear) begin
          alm_next      = ALM_RING;
          ring_cnt_next = '0;
        end
      end
      ALM_RING: begin
        if (alm_clear) begin
          alm_next      = ALM_IDLE;
          ring_cnt_next = '0;
        end else if (alm_match) begin
          ring_cnt_next = '0;
        end else if (tick_take) begin
          if (ring_cnt == RING_LAST) begin
            alm_next      = ALM_IDLE;
            ring_cnt_next = '0;
          end else begin
            ring_cnt_next = ring_cnt + 6'd1;
          end
        end
      end
      default: begin
        alm_next      = ALM_IDLE;
        ring_cnt_next = '0;
      end
    endcase
  end

  assign alarm_ring = (alm_state == ALM_RING);
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_en, alarm_hour, alarm_minute, alarm_clr, 6'(RING_SECS)};
  assign alarm_ring   = 1'b0;
`endif

endmodule

// File: doc/time_keeper.md
# time_keeper

Parametrised time-of-day core for the alarm-clock design: divides the system clock to a 1 s tick and keeps hour:minute:second with carry and wrap. Adds a run/freeze control, a validated single-cycle time load, a 12/24-hour display view and per-unit rollover strobes. An optional alarm comparator compiles in behind a macro. It feeds the display driver and alarm/buzzer logic.

## Interface
- CLK_DIV, 100000000: clk cycles per second; must be ≥ 2.
- DIV_W, 27: prescaler width; must satisfy 2^DIV_W ≥ CLK_DIV.
- RING_SECS, 60: alarm auto-stop duration in seconds; range 1..63.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = count, 0 = freeze prescaler and time.
- set_valid  in  1  one-cycle load request.
- set_hour  in  6  load value, binary 0..23.
- set_minute  in  6  load value, binary 0..59.
- set_second  in  6  load value, binary 0..59.
- mode12  in  1  1 = 12-hour view on disp_hour/pm.
- set_ack  out  1  pulse: load accepted.
- set_err  out  1  pulse: load rejected because a field is out of range.
- hour  out  6  binary 0..23.
- minute  out  6  binary 0..59.
- second  out  6  binary 0..59.
- disp_hour  out  6  hour in the view selected by mode12.
- pm  out  1  1 when hour ≥ 12, in both modes.
- sec_tick  out  1  pulse on every second increment.
- min_tick  out  1  pulse on 59→0 seconds.
- hour_tick  out  1  pulse on 59→0 minutes.
- day_tick  out  1  pulse on 23:59:59→00:00:00.
- alarm_en  in  1  arm alarm.
- alarm_hour  in  6  alarm hour, 0..23.
- alarm_minute  in  6  alarm minute, 0..59.
- alarm_clr  in  1  silence the ringing alarm.
- alarm_ring  out  1  alarm active.

## Operation
- Prescaler div_cnt counts 0..CLK_DIV-1 while run=1 and holds while run=0.
  - At div_cnt==CLK_DIV-1 with run=1: div_cnt←0 and the time advances by 1 s.
  - Carry chain: second 59→0 carries to minute; minute 59→0 carries to hour; hour 23→0.
- Load:
  - set_valid=1 with all fields in range: hour/minute/second←set values, div_cnt←0, set_ack=1.
  - set_valid=1 with any field out of range: time and div_cnt unchanged, set_err=1.
  - A load is evaluated identically whether run is 0 or 1.
- Priority on one edge: load > tick. A tick coinciding with an accepted load is dropped; that second restarts from 0.
- A rejected load does not block a coincident tick; the time advances normally.
- Display view:
  - mode12=0: disp_hour=hour.
  - mode12=1: hour 0 displays 12, hours 1..12 display unchanged, hours 13..23 display hour-12.
  - disp_hour and pm are combinational from hour and mode12.
- Width rule: all arithmetic is on 6-bit unsigned values. Range checks use compares, never modulo.

## Timing
- Reset (rst_n=0, asynchronous): div_cnt=0, time 00:00:00, alarm ring counter=0. All registered outputs are 0: set_ack, set_err, all *_tick, alarm_ring. disp_hour is 12 if mode12=1, else 0.
- Ticks, set_ack and set_err are registered single-cycle pulses. Each is high in the same cycle the updated time is first visible.
- The first tick after reset or after an accepted load occurs CLK_DIV cycles after the deassert/load edge, counting only cycles with run=1.
- day_tick ⊂ hour_tick ⊂ min_tick ⊂ sec_tick: these strobes assert together when the carries coincide.
- Releasing rst_n mid-second: counting restarts from 0. No partial-second state survives reset.

## Configuration
- Macro TIME_KEEPER_ALARM_EN.
- Defined:
  - On a sec_tick whose new time equals alarm_hour:alarm_minute:00 while alarm_en=1, alarm_ring←1 and the ring counter←0.
  - The ring counter increments on each later sec_tick.
  - alarm_ring clears on alarm_clr=1, on alarm_en=0, or when RING_SECS sec_ticks have elapsed.
  - Clear beats match on the same edge.
  - An accepted load never triggers a match, even when it lands exactly on the alarm time.
- Undefined: alarm_ring is tied 0 and the alarm inputs are ignored. Ports remain, so integration is unchanged.

## Test plan
- CLK_DIV=4; release reset, run=1 → sec_tick every 4 cycles, first on cycle 4; second counts 1,2,3…
- Load 23:59:58, run=1 → two ticks later time 00:00:00, with sec/min/hour/day_tick all high on the same cycle.
- Load 24:00:00 and separately 10:60:00 → set_err=1, set_ack=0, time unchanged; load 12:34:56 → set_ack=1, outputs 12:34:56.
- run=0 for 10 cycles mid-second → no tick, div_cnt held; run=1 → tick after the remaining count only. Load on a tick edge → tick dropped, next tick 4 cycles later.
- mode12=1 at hours 0, 12, 13, 23 → disp_hour 12, 12, 1, 11 and pm 0, 1, 1, 1.
- With TIME_KEEPER_ALARM_EN, RING_SECS=3, alarm 07:00, load 06:59:59 → alarm_ring rises at 07:00:00 and falls at 07:00:03. Repeat with alarm_clr at 07:00:01 → falls at 07:00:01. Pulse rst_n low while ringing → alarm_ring=0 immediately.
